// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone classic slave exposing NUM_REGS registers with byte-lane writes and programmable wait states.
// Define WB_SLAVE_REGFILE_ERR_EN to answer unmapped addresses with err_o instead of ack_o.
module wb_slave_regfile #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W     = 4;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_A = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic                    we_q, we_d;
    logic [NUM_BYTES-1:0]    sel_q, sel_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
`ifdef WB_SLAVE_REGFILE_ERR_EN
    logic                    err_q, err_d;
`endif

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic                    wr_en_c;
    logic                    mapped_c;
    logic [IDX_W-1:0]        idx_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    // Index decode uses the full latched address so high addresses never alias.
    assign mapped_c  = ({1'b0, adr_q} < NUM_REGS_A);
    assign idx_c     = IDX_W'(adr_q);
    assign rd_word_c = mapped_c ? regs_q[idx_c] : '0;

    // Next-state and response logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        ack_d   = ack_q;
        rdat_d  = rdat_q;
        wr_en_c = 1'b0;
`ifdef WB_SLAVE_REGFILE_ERR_EN
        err_d   = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    adr_d   = adr_i;
                    wdat_d  = dat_i;
                    we_d    = we_i;
                    sel_d   = sel_i;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                    if (mapped_c) begin
                        ack_d = 1'b1;
                        if (we_q) begin
                            wr_en_c = 1'b1;
                        end else begin
                            rdat_d = rd_word_c;
                        end
                    end else begin
`ifdef WB_SLAVE_REGFILE_ERR_EN
                        err_d = 1'b1;
`else
                        ack_d = 1'b1;
                        if (!we_q) begin
                            rdat_d = '0;
                        end
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (!cyc_i || !stb_i) begin
                    ack_d   = 1'b0;
`ifdef WB_SLAVE_REGFILE_ERR_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
`ifdef WB_SLAVE_REGFILE_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
`ifdef WB_SLAVE_REGFILE_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Register bank with per-byte write enables.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else if (wr_en_c) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (sel_q[k]) begin
                    regs_q[idx_c][8*k +: 8] <= wdat_q[8*k +: 8];
                end
            end
        end
    end

    assign dat_o = rdat_q;
    assign ack_o = stb_i & ack_q;
`ifdef WB_SLAVE_REGFILE_ERR_EN
    assign err_o = stb_i & err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/wb_slave_regfile.md
Name: wb_slave_regfile

Overview:
- Parametrised Wishbone classic slave exposing NUM_REGS read/write data registers with byte-lane write enables.
- Supports a programmable number of wait states and optional error signalling for unmapped addresses.
- Successor to the single fixed-latency slave register; sits on the shared Wishbone bus as a generic control/status register bank.

Parameters:
- ADDR_WIDTH, 8, width of adr_i.
- DATA_WIDTH, 8, width of dat_i/dat_o; must be a multiple of 8.
- NUM_REGS, 16, number of implemented registers; 1..2**ADDR_WIDTH.
- WAIT_STATES, 0, extra cycles inserted before ack; 0..15.
- RESET_VALUE, 0, value loaded into every register on reset (DATA_WIDTH bits).

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- adr_i  input  ADDR_WIDTH  word address; register index = adr_i, no byte offset.
- dat_i  input  DATA_WIDTH  write data.
- dat_o  output  DATA_WIDTH  read data, registered.
- we_i  input  1  1 = write, 0 = read.
- sel_i  input  DATA_WIDTH/8  byte-lane select; bit k covers dat bits [8k+7:8k].
- stb_i  input  1  strobe.
- cyc_i  input  1  bus cycle valid.
- ack_o  output  1  transfer acknowledge.
- err_o  output  1  transfer error; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All registers = RESET_VALUE; dat_o = 0.
  - Internal ack and err flags = 0; wait counter = 0; state = IDLE.
  - Reset asserted mid-transfer aborts the transfer with no write.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE: on an edge with cyc_i&stb_i=1, latch adr_i, dat_i, we_i and sel_i; counter <= WAIT_STATES; go to WAIT.
- WAIT:
  - counter != 0: decrement.
  - counter == 0: go to RESP.
- RESP: perform the access from the latched values, set ack (or err), go to HOLD.
- Latency: ack_o visible in the cycle after edge E(2+WAIT_STATES), counting the sampling edge as E0. WAIT_STATES=0 gives ack 2 cycles after the request is sampled.
- Write: for each k with sel=1, reg[idx] byte k <= dat byte k; other bytes keep their value. sel=0 gives ack with no change. dat_o is unchanged on writes.
- Read: dat_o <= reg[idx] (sel ignored; all lanes driven).
- Unmapped address (idx >= NUM_REGS): see Optional Feature.
- HOLD:
  - ack/err stay set while stb_i=1.
  - stb_i=0: clear both, return to IDLE.
  - A new request is sampled no earlier than the edge after returning to IDLE.
- Output gating: ack_o = stb_i & ack flag; err_o = stb_i & err flag. ack_o and err_o are never both 1.
- Abort: cyc_i=0 in WAIT, RESP or HOLD forces IDLE and clears the flags. If the abort happens before RESP, no write occurs.
- Changes to adr_i/dat_i after sampling are ignored until the next request.
- Address index uses the full adr_i width; no aliasing.

Optional Feature:
- Macro: WB_SLAVE_REGFILE_ERR_EN.
- Defined: an unmapped access raises err instead of ack. Writes are dropped; dat_o is unchanged.
- Undefined:
  - An unmapped access is acked normally; writes are dropped; reads load dat_o = 0.
  - err_o is constant 0.
- Timing of err matches ack timing in both builds.

Test Plan (DATA_WIDTH=16, NUM_REGS=8, WAIT_STATES=2 unless noted):
- Reset then read idx 3 -> ack_o rises after edge E4; dat_o=0x0000.
- Write 0xBEEF to idx 5 with sel=2'b11, then read idx 5 -> dat_o=0xBEEF. Write 0x1234 with sel=2'b01, then read -> 0xBE34.
- WAIT_STATES=0: read idx 0 -> ack_o rises after edge E2. Hold stb_i 3 extra cycles -> ack stays 1. Drop stb_i -> ack_o 0 at once; state back in IDLE next edge.
- Write 0xAAAA to idx 2, deassert cyc_i one cycle after sampling -> no ack; a later read of idx 2 returns the prior value 0x0000.
- Access idx 9 -> with WB_SLAVE_REGFILE_ERR_EN: err_o=1, ack_o=0, no write. Without it: ack_o=1, read dat_o=0x0000.
- Assert rst_i=0 in HOLD after a write to idx 1 -> ack_o drops immediately; read idx 1 -> RESET_VALUE.
